// File: rtl/mem_bus_arbiter.sv
// Three-port arbiter in front of a single-port memory: one owner per access, read data back to it.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_W-1:0]     addr,
  input  logic [3*DATA_W-1:0]     wdata,
  input  logic [3*DATA_W/8-1:0]   wstrb,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_wstrb,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  state_e      state_q;
  logic [1:0]  owner_q;
  logic [2:0]  cnt_q;
  logic [1:0]  win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]  last_q;

  // Search starts just after the last granted port.
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end
`else
  always_comb begin
    win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      cnt_q     <= 3'd0;
      gnt       <= 3'b000;
      rvalid    <= 3'b000;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 2'd2;
`endif
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      gnt       <= 3'b000;
      rvalid    <= 3'b000;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q   <= StAccess;
            owner_q   <= win;
            gnt       <= 3'b001 << win;
            mem_en    <= 1'b1;
            mem_we    <= we[win];
            mem_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
            mem_wstrb <= we[win] ? wstrb[int'(win)*STRB_W +: STRB_W] : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= win;
`endif
          end
        end
        StAccess: begin
          if (mem_we) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'(MEM_LAT);
          end
        end
        StWait: begin
          // Last wait cycle: mem_rdata is valid now.
          if (cnt_q == 3'd1) begin
            rdata   <= mem_rdata;
            rvalid  <= 3'b001 << owner_q;
            cnt_q   <= 3'd0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
